pc_fetch_ctrl: RTL and testbench

- Owns the architectural fetch PC register and sequences it each cycle.
- Arbitrates sequential advance, CSR redirects (trap/mret/irq) and EXE redirects (branch/jump).
- Buffers a redirect while the fetch unit is stalled and parks fetch during WFI.
- Sits between the CSR unit, the EXE stage and the instruction-fetch interface.

---
 rtl/pc_ctrl_pkg.sv | 18 +
 rtl/pc_redirect_arb.sv | 34 +++
 rtl/pc_fetch_ctrl.sv | 150 +++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch PC controller and its redirect arbiter.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    SLEEP = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CSR  = 2'd1,
    EXE  = 2'd2
  } redir_src_e;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational CSR-over-EXE redirect priority select; targets are forced word aligned.
module pc_redirect_arb
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            csr_req_i,
  input  logic [XLEN-1:0] csr_pc_i,
  input  logic            exe_req_i,
  input  logic [XLEN-1:0] exe_pc_i,
  input  logic            exe_en_i,
  output logic            redir_vld_o,
  output redir_src_e      redir_src_o,
  output logic [XLEN-1:0] redir_pc_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  always_comb begin
    redir_vld_o = 1'b0;
    redir_src_o = NONE;
    redir_pc_o  = '0;
    if (csr_req_i) begin
      redir_vld_o = 1'b1;
      redir_src_o = CSR;
      redir_pc_o  = csr_pc_i & ALIGN_MASK;
    end else if (exe_req_i && exe_en_i) begin
      redir_vld_o = 1'b1;
      redir_src_o = EXE;
      redir_pc_o  = exe_pc_i & ALIGN_MASK;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC owner: sequential advance, CSR/EXE redirects, stall-time redirect buffering, WFI parking.
// Optional PC_FETCH_CTRL_PERF_EN adds redirect_cnt / sleep_cycles counters.
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_new_pc_req,
  input  logic [XLEN-1:0] csr_new_pc,
  input  logic            exe_new_pc_req,
  input  logic [XLEN-1:0] exe_new_pc,
  input  logic            wfi_req,
  input  logic            irq_pending,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc_ff,
  output logic            flush,
  output logic            wfi_sleep
`ifdef PC_FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     sleep_cycles
`endif
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  redir_src_e      pend_src_q, pend_src_d;

  logic            redir_vld;
  redir_src_e      redir_src;
  logic [XLEN-1:0] redir_pc;
  logic            exe_en;
  logic            redir_apply;

  // A buffered CSR target must not be displaced by a younger EXE redirect.
  assign exe_en = (state_q == RUN) || ((state_q == PEND) && (pend_src_q == EXE));

  pc_redirect_arb #(.XLEN(XLEN)) u_arb (
    .csr_req_i   (csr_new_pc_req),
    .csr_pc_i    (csr_new_pc),
    .exe_req_i   (exe_new_pc_req),
    .exe_pc_i    (exe_new_pc),
    .exe_en_i    (exe_en),
    .redir_vld_o (redir_vld),
    .redir_src_o (redir_src),
    .redir_pc_o  (redir_pc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    pend_src_d  = pend_src_q;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    wfi_sleep   = 1'b0;
    redir_apply = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (redir_vld) begin
            flush = 1'b1;
            if (fetch_ready) begin
              pc_d        = redir_pc;
              redir_apply = 1'b1;
            end else begin
              pend_pc_d  = redir_pc;
              pend_src_d = redir_src;
              state_d    = PEND;
            end
          end else if (wfi_req) begin
            flush   = 1'b1;
            state_d = SLEEP;
          end else begin
            fetch_valid = 1'b1;
            if (fetch_ready) pc_d = pc_q + XLEN'(PC_INC);
          end
        end
        PEND: begin
          flush = redir_vld;
          if (redir_vld) begin
            pend_pc_d  = redir_pc;
            pend_src_d = redir_src;
          end
          if (fetch_ready) begin
            pc_d        = redir_vld ? redir_pc : pend_pc_q;
            pend_src_d  = NONE;
            state_d     = RUN;
            redir_apply = 1'b1;
          end
        end
        SLEEP: begin
          wfi_sleep = 1'b1;
          if (redir_vld) begin
            flush       = 1'b1;
            pc_d        = redir_pc;
            state_d     = RUN;
            redir_apply = 1'b1;
          end else if (irq_pending) begin
            pc_d    = pc_q + XLEN'(PC_INC);
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_VECTOR;
      pend_pc_q  <= '0;
      pend_src_q <= NONE;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_src_q <= pend_src_d;
    end
  end

  assign pc_ff = pc_q;

`ifdef PC_FETCH_CTRL_PERF_EN
  logic [31:0] redirect_cnt_q, sleep_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_q <= '0;
      sleep_cycles_q <= '0;
    end else begin
      if (redir_apply) redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (state_q == SLEEP) sleep_cycles_q <= sleep_cycles_q + 32'd1;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign sleep_cycles = sleep_cycles_q;
`else
  logic unused_apply;
  assign unused_apply = redir_apply;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed plus randomized bench for pc_fetch_ctrl against an event-level reference model.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_new_pc_req;
  logic [31:0] csr_new_pc;
  logic        exe_new_pc_req;
  logic [31:0] exe_new_pc;
  logic        wfi_req;
  logic        irq_pending;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] pc_ff;
  logic        flush;
  logic        wfi_sleep;
`ifdef PC_FETCH_CTRL_PERF_EN
  logic [31:0] redirect_cnt;
  logic [31:0] sleep_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: the core is either running, holding a buffered target, or asleep.
  logic [31:0] m_pc;
  bit          m_sleep;
  bit          m_pend;
  bit          m_pend_csr;
  logic [31:0] m_pend_pc;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .csr_new_pc_req (csr_new_pc_req),
    .csr_new_pc     (csr_new_pc),
    .exe_new_pc_req (exe_new_pc_req),
    .exe_new_pc     (exe_new_pc),
    .wfi_req        (wfi_req),
    .irq_pending    (irq_pending),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fetch_valid),
    .pc_ff          (pc_ff),
    .flush          (flush),
    .wfi_sleep      (wfi_sleep)
`ifdef PC_FETCH_CTRL_PERF_EN
    ,
    .redirect_cnt   (redirect_cnt),
    .sleep_cycles   (sleep_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, compare combinational outputs, then advance the model.
  task automatic cycle(input bit r, input bit cr, input logic [31:0] cp,
                       input bit er, input logic [31:0] ep,
                       input bit w, input bit ir, input bit rd);
    bit          take, csr_hit, exe_hit, e_flush, e_valid, e_sleep;
    logic [31:0] tgt;
    @(negedge clk);
    rst = r; csr_new_pc_req = cr; csr_new_pc = cp;
    exe_new_pc_req = er; exe_new_pc = ep;
    wfi_req = w; irq_pending = ir; fetch_ready = rd;
    #1;
    csr_hit = cr;
    exe_hit = er && !m_sleep && !(m_pend && m_pend_csr);
    take    = csr_hit || exe_hit;
    tgt     = (csr_hit ? cp : ep) & 32'hFFFF_FFFC;
    e_sleep = !r && m_sleep;
    e_flush = !r && (take || (w && !m_sleep && !m_pend));
    e_valid = !r && !m_sleep && !m_pend && !e_flush;
    check("pc_ff", pc_ff, m_pc);
    check("flush", {31'b0, flush}, {31'b0, e_flush});
    check("fetch_valid", {31'b0, fetch_valid}, {31'b0, e_valid});
    check("wfi_sleep", {31'b0, wfi_sleep}, {31'b0, e_sleep});
    if (r) begin
      m_pc = 32'h0; m_sleep = 0; m_pend = 0; m_pend_csr = 0; m_pend_pc = 32'h0;
    end else if (m_sleep) begin
      if (csr_hit) begin m_pc = tgt; m_sleep = 0; end
      else if (ir) begin m_pc = m_pc + 32'd4; m_sleep = 0; end
    end else if (m_pend) begin
      if (take) begin m_pend_pc = tgt; m_pend_csr = csr_hit; end
      if (rd) begin m_pc = m_pend_pc; m_pend = 0; end
    end else if (take) begin
      if (rd) m_pc = tgt;
      else begin m_pend = 1; m_pend_pc = tgt; m_pend_csr = csr_hit; end
    end else if (w) begin
      m_sleep = 1;
    end else if (rd) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic idle(input bit rd);
    cycle(0, 0, 32'h0, 0, 32'h0, 0, 0, rd);
  endtask

  task automatic exe(input logic [31:0] t, input bit rd);
    cycle(0, 0, 32'h0, 1, t, 0, 0, rd);
  endtask

  task automatic csr(input logic [31:0] t, input bit rd);
    cycle(0, 1, t, 0, 32'h0, 0, 0, rd);
  endtask

  initial begin
    rst = 1; csr_new_pc_req = 0; csr_new_pc = 0; exe_new_pc_req = 0; exe_new_pc = 0;
    wfi_req = 0; irq_pending = 0; fetch_ready = 0;
    m_pc = 0; m_sleep = 0; m_pend = 0; m_pend_csr = 0; m_pend_pc = 0;

    // Reset state
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    check("rst_valid", {31'b0, fetch_valid}, 32'h0);
    cycle(1, 1, 32'h1234, 0, 0, 0, 0, 1);
    check("rst_flush", {31'b0, flush}, 32'h0);

    // Sequential fetch from reset vector
    idle(1); check("seq0", pc_ff, 32'h0); check("seq_valid", {31'b0, fetch_valid}, 32'h1);
    idle(1); check("seq1", pc_ff, 32'h4);
    idle(1); check("seq2", pc_ff, 32'h8);
    idle(0); check("seq3", pc_ff, 32'hC);

    // EXE redirect, misaligned target
    exe(32'h100, 1);
    exe(32'h2002, 1); check("exe_pc_before", pc_ff, 32'h100); check("exe_flush", {31'b0, flush}, 32'h1);
    idle(0); check("exe_pc_after", pc_ff, 32'h2000);

    // Stalled EXE redirect overwritten by CSR while pending
    exe(32'h300, 0);
    csr(32'h8000_0000, 0); check("pend_valid0", {31'b0, fetch_valid}, 32'h0);
    exe(32'h700, 0); check("pend_exe_ignored_flush", {31'b0, flush}, 32'h0);
    idle(1); check("pend_valid1", {31'b0, fetch_valid}, 32'h0);
    idle(0); check("pend_applied", pc_ff, 32'h8000_0000);

    // Simultaneous CSR and EXE
    cycle(0, 1, 32'h400, 1, 32'h500, 0, 0, 1);
    idle(0); check("csr_wins", pc_ff, 32'h400);

    // WFI and irq wake
    exe(32'h40, 1);
    cycle(0, 0, 0, 0, 0, 1, 0, 1); check("wfi_pc", pc_ff, 32'h40);
    for (int i = 0; i < 5; i++) begin
      idle(1); check("sleeping", {31'b0, wfi_sleep}, 32'h1);
    end
    exe(32'h900, 1); check("sleep_exe_ignored", {31'b0, wfi_sleep}, 32'h1);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    idle(0); check("irq_wake_pc", pc_ff, 32'h44); check("irq_wake_sleep", {31'b0, wfi_sleep}, 32'h0);

    // WFI with CSR wake
    cycle(0, 0, 0, 0, 0, 1, 0, 1);
    idle(0); idle(0);
    csr(32'h8000_0010, 0);
    idle(0); check("csr_wake_pc", pc_ff, 32'h8000_0010);

    // WFI alongside a redirect: the redirect wins
    cycle(0, 0, 0, 1, 32'h60, 1, 0, 1);
    idle(0); check("wfi_dropped", {31'b0, wfi_sleep}, 32'h0); check("wfi_dropped_pc", pc_ff, 32'h60);

    // PC wrap
    exe(32'hFFFF_FFFC, 1);
    idle(1); check("wrap_before", pc_ff, 32'hFFFF_FFFC);
    idle(0); check("wrap_after", pc_ff, 32'h0);

    // Reset while a target is pending
    exe(32'h600, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1); check("rst_pend_pc", pc_ff, 32'h0);
    idle(0); check("rst_pend_discard", pc_ff, 32'h4);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(99) == 0),
            ($urandom_range(7) == 0), $urandom,
            ($urandom_range(4) == 0), $urandom,
            ($urandom_range(9) == 0),
            ($urandom_range(5) == 0),
            ($urandom_range(2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
